// File: rtl/role_mem_tester_pkg.sv
// Shared types, DataMover command/status field layout and helpers for the
// Up0 memory traffic engine.
package role_mem_tester_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_WR_DATA,
        S_WR_STS,
        S_RD_CMD,
        S_RD_DATA,
        S_RD_STS,
        S_DONE
    } state_t;

    localparam int IDX_W        = 13;
    localparam int CMD_W        = 72;
    localparam int CMD_BTT_LSB  = 0;
    localparam int CMD_BTT_W    = 23;
    localparam int CMD_TYPE_BIT = 23;
    localparam int CMD_DSA_LSB  = 24;
    localparam int CMD_EOF_BIT  = 30;
    localparam int CMD_DRR_BIT  = 31;
    localparam int CMD_ADDR_LSB = 32;
    localparam int CMD_TAG_LSB  = 64;

    localparam int STS_OKAY_BIT = 7;
    localparam int STS_ERR_LSB  = 4;
    localparam int STS_TAG_LSB  = 0;

    function automatic logic [CMD_W-1:0] mk_dm_cmd(input logic [31:0] addr,
                                                   input logic [22:0] btt,
                                                   input logic [3:0]  tag);
        logic [CMD_W-1:0] cmd;
        cmd = '0;
        cmd[CMD_BTT_LSB +: CMD_BTT_W] = btt;
        cmd[CMD_TYPE_BIT]             = 1'b1;
        cmd[CMD_DSA_LSB +: 6]         = 6'd0;
        cmd[CMD_EOF_BIT]              = 1'b1;
        cmd[CMD_DRR_BIT]              = 1'b0;
        cmd[CMD_ADDR_LSB +: 32]       = addr;
        cmd[CMD_TAG_LSB +: 4]         = tag;
        return cmd;
    endfunction

    function automatic logic sts_ok(input logic [7:0] sts, input logic [3:0] tag);
        return sts[STS_OKAY_BIT] && (sts[STS_ERR_LSB +: 3] == 3'b000) &&
               (sts[STS_TAG_LSB +: 4] == tag);
    endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Beat counter plus seed adder: produces beat i = 8 copies of (seed + i),
// registered, advancing one beat per accepted transfer.
module mem_pattern_gen
    import role_mem_tester_pkg::*;
#(
    parameter int BEATS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         advance,
    input  logic [63:0]  seed,
    output logic [511:0] data,
    output logic         last
);

    logic [63:0]      word_p0;
    logic [IDX_W-1:0] idx_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_p0 <= '0;
            idx_p0  <= '0;
        end else if (load) begin
            word_p0 <= seed;
            idx_p0  <= '0;
        end else if (advance) begin
            word_p0 <= word_p0 + 64'd1;
            idx_p0  <= idx_p0 + IDX_W'(1);
        end
    end

    assign data = {8{word_p0}};
    assign last = (idx_p0 == IDX_W'(BEATS - 1));

endmodule

// File: rtl/role_mem_tester.sv
// Up0 memory tester: writes one seeded burst through the DataMover streams,
// reads it back and checks every beat, reporting pass/fail/timeout.
module role_mem_tester
    import role_mem_tester_pkg::*;
#(
    parameter int BEATS   = 64,
    parameter int TIMEOUT = 65535
) (
    input  logic         piSHL_156_25Clk,
    input  logic         piTOP_Reset_n,
    input  logic         piStart,
    input  logic [31:0]  piAddr,
    input  logic [63:0]  piSeed,
    output logic         poBusy,
    output logic         poDone,
    output logic         poPass,
    output logic         poTimeout,
    output logic [15:0]  poErrCnt,
    output logic [71:0]  up0_rd_cmd_tdata,
    output logic         up0_rd_cmd_tvalid,
    input  logic         up0_rd_cmd_tready,
    input  logic [7:0]   up0_rd_sts_tdata,
    input  logic         up0_rd_sts_tvalid,
    output logic         up0_rd_sts_tready,
    input  logic [511:0] up0_rd_tdata,
    input  logic [63:0]  up0_rd_tkeep,
    input  logic         up0_rd_tlast,
    input  logic         up0_rd_tvalid,
    output logic         up0_rd_tready,
    output logic [71:0]  up0_wr_cmd_tdata,
    output logic         up0_wr_cmd_tvalid,
    input  logic         up0_wr_cmd_tready,
    input  logic [7:0]   up0_wr_sts_tdata,
    input  logic         up0_wr_sts_tvalid,
    output logic         up0_wr_sts_tready,
    output logic [511:0] up0_wr_tdata,
    output logic [63:0]  up0_wr_tkeep,
    output logic         up0_wr_tlast,
    output logic         up0_wr_tvalid,
    input  logic         up0_wr_tready
);

    localparam logic [22:0] BTT = 23'(BEATS * 64);

    state_t        state, state_nx;
    logic [3:0]    tag;
    logic [71:0]   cmd;
    logic [31:0]   tmo_cnt;
    logic [15:0]   err_cnt;
    logic          mis_p1;
    logic          sts_err, rd_sts_seen;
    logic          done_flag, pass_flag, tmo_flag;

    logic          start_acc, tmo_hit, any_hs, rd_mismatch;
    logic          wr_cmd_hs, wr_hs, wr_sts_hs, rd_cmd_hs, rd_hs, rd_sts_hs;
    logic          wr_last, rd_exp_last;
    logic [511:0]  rd_exp_data;

    mem_pattern_gen #(.BEATS(BEATS)) u_wr_gen (
        .clk     (piSHL_156_25Clk),
        .rst_n   (piTOP_Reset_n),
        .load    (start_acc),
        .advance (wr_hs),
        .seed    (piSeed),
        .data    (up0_wr_tdata),
        .last    (wr_last)
    );

    mem_pattern_gen #(.BEATS(BEATS)) u_rd_chk (
        .clk     (piSHL_156_25Clk),
        .rst_n   (piTOP_Reset_n),
        .load    (start_acc),
        .advance (rd_hs),
        .seed    (piSeed),
        .data    (rd_exp_data),
        .last    (rd_exp_last)
    );

    assign up0_wr_cmd_tvalid = (state == S_WR_CMD);
    assign up0_rd_cmd_tvalid = (state == S_RD_CMD);
    assign up0_wr_tvalid     = (state == S_WR_DATA);
    assign up0_wr_tlast      = up0_wr_tvalid && wr_last;
    assign up0_wr_tkeep      = {64{up0_wr_tvalid}};
    assign up0_wr_sts_tready = (state == S_WR_STS);
    assign up0_rd_tready     = (state == S_RD_DATA);
    assign up0_rd_sts_tready = ((state == S_RD_DATA) || (state == S_RD_STS)) && !rd_sts_seen;
    assign up0_wr_cmd_tdata  = cmd;
    assign up0_rd_cmd_tdata  = cmd;

    assign poBusy    = (state != S_IDLE);
    assign poDone    = done_flag;
    assign poPass    = pass_flag;
    assign poTimeout = tmo_flag;
    assign poErrCnt  = err_cnt;

    assign start_acc = piStart && (state == S_IDLE);
    assign wr_cmd_hs = up0_wr_cmd_tvalid && up0_wr_cmd_tready;
    assign wr_hs     = up0_wr_tvalid && up0_wr_tready;
    assign wr_sts_hs = up0_wr_sts_tvalid && up0_wr_sts_tready;
    assign rd_cmd_hs = up0_rd_cmd_tvalid && up0_rd_cmd_tready;
    assign rd_hs     = up0_rd_tvalid && up0_rd_tready;
    assign rd_sts_hs = up0_rd_sts_tvalid && up0_rd_sts_tready;
    assign any_hs    = wr_cmd_hs || wr_hs || wr_sts_hs || rd_cmd_hs || rd_hs || rd_sts_hs;

    // A handshake in the expiring cycle counts as progress, not as a timeout.
    assign tmo_hit = (state != S_IDLE) && (state != S_DONE) && !any_hs &&
                     (tmo_cnt == 32'(TIMEOUT - 1));

    assign rd_mismatch = (up0_rd_tdata != rd_exp_data) || (up0_rd_tkeep != '1) ||
                         (up0_rd_tlast != rd_exp_last);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (piStart)                  state_nx = S_WR_CMD;
            S_WR_CMD:  if (wr_cmd_hs)                state_nx = S_WR_DATA;
            S_WR_DATA: if (wr_hs && wr_last)         state_nx = S_WR_STS;
            S_WR_STS:  if (wr_sts_hs)                state_nx = S_RD_CMD;
            S_RD_CMD:  if (rd_cmd_hs)                state_nx = S_RD_DATA;
            S_RD_DATA: if (rd_hs && rd_exp_last)     state_nx = S_RD_STS;
            S_RD_STS:  if (rd_sts_seen || rd_sts_hs) state_nx = S_DONE;
            S_DONE:                                  state_nx = S_IDLE;
            default:                                 state_nx = S_IDLE;
        endcase
        if (tmo_hit) state_nx = S_DONE;
    end

    // Stage p1: registered beat compare; error count folds it in one cycle later,
    // which RD_STS always covers before DONE samples the count.
    always_ff @(posedge piSHL_156_25Clk) begin
        if (!piTOP_Reset_n) begin
            state       <= S_IDLE;
            tag         <= 4'd0;
            cmd         <= '0;
            tmo_cnt     <= '0;
            err_cnt     <= '0;
            mis_p1      <= 1'b0;
            sts_err     <= 1'b0;
            rd_sts_seen <= 1'b0;
            done_flag   <= 1'b0;
            pass_flag   <= 1'b0;
            tmo_flag    <= 1'b0;
        end else begin
            state  <= state_nx;
            mis_p1 <= rd_hs && rd_mismatch;
            if ((state_nx != state) || any_hs || (state == S_IDLE))
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 32'd1;

            if (start_acc) begin
                tag         <= tag + 4'd1;
                cmd         <= mk_dm_cmd(piAddr, BTT, tag + 4'd1);
                err_cnt     <= '0;
                sts_err     <= 1'b0;
                rd_sts_seen <= 1'b0;
                done_flag   <= 1'b0;
                pass_flag   <= 1'b0;
                tmo_flag    <= 1'b0;
            end else begin
                if (mis_p1 && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
                if (wr_sts_hs && !sts_ok(up0_wr_sts_tdata, tag)) sts_err <= 1'b1;
                if (rd_sts_hs) begin
                    rd_sts_seen <= 1'b1;
                    if (!sts_ok(up0_rd_sts_tdata, tag)) sts_err <= 1'b1;
                end
                if (tmo_hit) tmo_flag <= 1'b1;
                if (state == S_DONE) begin
                    done_flag <= 1'b1;
                    pass_flag <= (err_cnt == 16'd0) && !sts_err && !tmo_flag;
                end
            end
        end
    end

endmodule

// File: tb/tb_role_mem_tester.sv
// Directed bench for role_mem_tester: a cycle-stepped Up0 memory model driven
// from one initial block, with immediate-assertion checks at each step.
module tb_role_mem_tester;

    localparam int B   = 4;
    localparam int TMO = 100;

    logic         clk;
    logic         rst_n;
    logic         piStart;
    logic [31:0]  piAddr;
    logic [63:0]  piSeed;
    logic         poBusy, poDone, poPass, poTimeout;
    logic [15:0]  poErrCnt;
    logic [71:0]  up0_rd_cmd_tdata;
    logic         up0_rd_cmd_tvalid, up0_rd_cmd_tready;
    logic [7:0]   up0_rd_sts_tdata;
    logic         up0_rd_sts_tvalid, up0_rd_sts_tready;
    logic [511:0] up0_rd_tdata;
    logic [63:0]  up0_rd_tkeep;
    logic         up0_rd_tlast, up0_rd_tvalid, up0_rd_tready;
    logic [71:0]  up0_wr_cmd_tdata;
    logic         up0_wr_cmd_tvalid, up0_wr_cmd_tready;
    logic [7:0]   up0_wr_sts_tdata;
    logic         up0_wr_sts_tvalid, up0_wr_sts_tready;
    logic [511:0] up0_wr_tdata;
    logic [63:0]  up0_wr_tkeep;
    logic         up0_wr_tlast, up0_wr_tvalid, up0_wr_tready;

    role_mem_tester #(.BEATS(B), .TIMEOUT(TMO)) dut (
        .piSHL_156_25Clk   (clk),
        .piTOP_Reset_n     (rst_n),
        .piStart           (piStart),
        .piAddr            (piAddr),
        .piSeed            (piSeed),
        .poBusy            (poBusy),
        .poDone            (poDone),
        .poPass            (poPass),
        .poTimeout         (poTimeout),
        .poErrCnt          (poErrCnt),
        .up0_rd_cmd_tdata  (up0_rd_cmd_tdata),
        .up0_rd_cmd_tvalid (up0_rd_cmd_tvalid),
        .up0_rd_cmd_tready (up0_rd_cmd_tready),
        .up0_rd_sts_tdata  (up0_rd_sts_tdata),
        .up0_rd_sts_tvalid (up0_rd_sts_tvalid),
        .up0_rd_sts_tready (up0_rd_sts_tready),
        .up0_rd_tdata      (up0_rd_tdata),
        .up0_rd_tkeep      (up0_rd_tkeep),
        .up0_rd_tlast      (up0_rd_tlast),
        .up0_rd_tvalid     (up0_rd_tvalid),
        .up0_rd_tready     (up0_rd_tready),
        .up0_wr_cmd_tdata  (up0_wr_cmd_tdata),
        .up0_wr_cmd_tvalid (up0_wr_cmd_tvalid),
        .up0_wr_cmd_tready (up0_wr_cmd_tready),
        .up0_wr_sts_tdata  (up0_wr_sts_tdata),
        .up0_wr_sts_tvalid (up0_wr_sts_tvalid),
        .up0_wr_sts_tready (up0_wr_sts_tready),
        .up0_wr_tdata      (up0_wr_tdata),
        .up0_wr_tkeep      (up0_wr_tkeep),
        .up0_wr_tlast      (up0_wr_tlast),
        .up0_wr_tvalid     (up0_wr_tvalid),
        .up0_wr_tready     (up0_wr_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit          gap, corrupt, sts_never, start_mid;
    logic [3:0]  wsts_hi;
    int          stop_wr;
    logic [63:0] cur_seed;
    logic [31:0] cur_addr;
    logic [3:0]  cur_tag;
    logic [511:0] mem [B];
    int          tlast_cyc, tmo_cyc, wr_cnt_o, rd_cnt_o;

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endtask

    function automatic bit rnd();
        if (gap) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic drive_idle();
        piStart = 0; piAddr = '0; piSeed = '0;
        up0_rd_cmd_tready = 0; up0_wr_cmd_tready = 0; up0_wr_tready = 0;
        up0_rd_sts_tdata = '0; up0_rd_sts_tvalid = 0;
        up0_wr_sts_tdata = '0; up0_wr_sts_tvalid = 0;
        up0_rd_tdata = '0; up0_rd_tkeep = '0; up0_rd_tlast = 0; up0_rd_tvalid = 0;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_busy"}, poBusy, 0);
        chk({p, "_done"}, poDone, 0);
        chk({p, "_pass"}, poPass, 0);
        chk({p, "_tmo"}, poTimeout, 0);
        chk({p, "_errcnt"}, poErrCnt, 0);
        chk({p, "_wrcmd_vld"}, up0_wr_cmd_tvalid, 0);
        chk({p, "_wrcmd_data"}, up0_wr_cmd_tdata, 0);
        chk({p, "_rdcmd_vld"}, up0_rd_cmd_tvalid, 0);
        chk({p, "_rdcmd_data"}, up0_rd_cmd_tdata, 0);
        chk({p, "_wr_vld"}, up0_wr_tvalid, 0);
        chk({p, "_wr_last"}, up0_wr_tlast, 0);
        chk({p, "_wr_keep"}, up0_wr_tkeep, 0);
        chk({p, "_wr_data"}, up0_wr_tdata, 0);
        chk({p, "_wrsts_rdy"}, up0_wr_sts_tready, 0);
        chk({p, "_rd_rdy"}, up0_rd_tready, 0);
        chk({p, "_rdsts_rdy"}, up0_rd_sts_tready, 0);
    endtask

    task automatic start_run(input logic [31:0] a, input logic [63:0] s, input logic [3:0] t);
        @(negedge clk);
        drive_idle();
        piStart = 1; piAddr = a; piSeed = s;
        cur_addr = a; cur_seed = s; cur_tag = t;
        @(negedge clk);
        piStart = 0;
        #1;
        chk("start_busy", poBusy, 1);
        chk("start_wrcmd_vld", up0_wr_cmd_tvalid, 1);
        chk("start_done_clr", poDone, 0);
    endtask

    task automatic serve();
        bit rd_pres, ws_pres, rs_pres, ws_pend, rs_pend, rd_go, prev_busy;
        bit hs_wc, hs_w, hs_ws, hs_rc, hs_r, hs_rs;
        int wr_n, rd_n;
        logic [511:0] rdata;
        logic [71:0]  exp_cmd;
        rd_pres = 0; ws_pres = 0; rs_pres = 0; ws_pend = 0; rs_pend = 0; rd_go = 0;
        prev_busy = 1; wr_n = 0; rd_n = 0; tlast_cyc = -1; tmo_cyc = -1;
        exp_cmd = {4'h0, cur_tag, cur_addr, 32'h4080_0100};
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (stop_wr >= 0 && wr_n == stop_wr) break;
            if (start_mid && cyc == 5) begin
                piStart = 1; piAddr = 32'hDEAD_0000; piSeed = 64'hBAD;
            end else begin
                piStart = 0;
            end
            up0_wr_cmd_tready = rnd();
            up0_wr_tready     = rnd();
            up0_rd_cmd_tready = rnd();
            if (ws_pend && !ws_pres && !sts_never) ws_pres = rnd();
            up0_wr_sts_tvalid = ws_pres;
            up0_wr_sts_tdata  = {wsts_hi, cur_tag};
            if (rd_go && rd_n < B && !rd_pres) rd_pres = rnd();
            rdata = '0;
            if (rd_n < B) rdata = mem[rd_n];
            if (corrupt && rd_n == 2) rdata[0] = ~rdata[0];
            up0_rd_tvalid = rd_pres;
            up0_rd_tdata  = rd_pres ? rdata : '0;
            up0_rd_tkeep  = rd_pres ? '1 : '0;
            up0_rd_tlast  = rd_pres && (rd_n == B - 1);
            if (rs_pend && !rs_pres) rs_pres = rnd();
            up0_rd_sts_tvalid = rs_pres;
            up0_rd_sts_tdata  = {4'h8, cur_tag};
            #1;
            if (poTimeout && tmo_cyc < 0) tmo_cyc = cyc;
            if (poDone) begin
                chk("done_busy_low", poBusy, 0);
                chk("done_busy_prev", prev_busy, 1);
                break;
            end
            prev_busy = poBusy;
            hs_wc = up0_wr_cmd_tvalid && up0_wr_cmd_tready;
            hs_w  = up0_wr_tvalid && up0_wr_tready;
            hs_ws = up0_wr_sts_tvalid && up0_wr_sts_tready;
            hs_rc = up0_rd_cmd_tvalid && up0_rd_cmd_tready;
            hs_r  = up0_rd_tvalid && up0_rd_tready;
            hs_rs = up0_rd_sts_tvalid && up0_rd_sts_tready;
            if (hs_wc) chk("wrcmd_word", up0_wr_cmd_tdata, exp_cmd);
            if (hs_w) begin
                chk("wr_beat_data", up0_wr_tdata, {8{cur_seed + 64'(wr_n)}});
                chk("wr_beat_last", up0_wr_tlast, (wr_n == B - 1));
                chk("wr_beat_keep", up0_wr_tkeep, {64{1'b1}});
                if (wr_n < B) mem[wr_n] = up0_wr_tdata;
                if (up0_wr_tlast) begin ws_pend = 1; tlast_cyc = cyc; end
                wr_n++;
            end
            if (hs_ws) begin ws_pres = 0; ws_pend = 0; end
            if (hs_rc) begin chk("rdcmd_word", up0_rd_cmd_tdata, exp_cmd); rd_go = 1; end
            if (hs_r) begin
                rd_pres = 0; rd_n++;
                if (rd_n == B) rs_pend = 1;
            end
            if (hs_rs) begin rs_pres = 0; rs_pend = 0; end
            @(negedge clk);
        end
        if (stop_wr < 0) chk("done_reached", poDone, 1);
        wr_cnt_o = wr_n;
        rd_cnt_o = rd_n;
    endtask

    task automatic chk_result(input string p, input bit pass, input logic [15:0] errs,
                              input bit tmo, input int wr_n, input int rd_n);
        chk({p, "_pass"}, poPass, pass);
        chk({p, "_errcnt"}, poErrCnt, errs);
        chk({p, "_timeout"}, poTimeout, tmo);
        chk({p, "_wr_beats"}, wr_cnt_o, wr_n);
        chk({p, "_rd_beats"}, rd_cnt_o, rd_n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        gap = 0; corrupt = 0; sts_never = 0; start_mid = 0; wsts_hi = 4'h8; stop_wr = -1;
        rst_n = 0;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // Run 1: clean burst, tag 1, command word checked against hand value.
        start_run(32'h0000_1000, 64'h10, 4'd1);
        chk("run1_cmd_hand", up0_wr_cmd_tdata, 72'h1_0000_1000_4080_0100);
        chk("run1_beat0_hand", up0_wr_tdata, {8{64'h10}});
        serve();
        chk_result("run1", 1, 16'd0, 0, 4, 4);
        repeat (3) @(negedge clk);
        #1;
        chk("run1_done_hold", poDone, 1);
        chk("run1_pass_hold", poPass, 1);
        chk("run1_idle_busy", poBusy, 0);

        // Run 2: corrupt read beat 2 word 0; seed wraps through 2^64.
        corrupt = 1;
        start_run(32'h0000_2000, 64'hFFFF_FFFF_FFFF_FFFE, 4'd2);
        serve();
        chk_result("run2", 0, 16'd1, 0, 4, 4);
        corrupt = 0;

        // Run 3: 50% gaps everywhere plus a start pulse while busy.
        gap = 1; start_mid = 1;
        start_run(32'h0000_0040, 64'h1234_5678_9ABC_DEF0, 4'd3);
        serve();
        chk_result("run3", 1, 16'd0, 0, 4, 4);
        gap = 0; start_mid = 0;

        // Run 4: write status SLVERR; tag 4 proves the busy start was ignored.
        wsts_hi = 4'h4;
        start_run(32'h0000_8000, 64'h55, 4'd4);
        serve();
        chk_result("run4", 0, 16'd0, 0, 4, 4);
        wsts_hi = 4'h8;

        // Run 5: write status never arrives.
        sts_never = 1;
        start_run(32'h0001_0000, 64'h99, 4'd5);
        serve();
        chk_result("run5", 0, 16'd0, 1, 4, 0);
        chk("run5_done", poDone, 1);
        chk("run5_tmo_delay_ok", ((tmo_cyc - tlast_cyc) >= 99) && ((tmo_cyc - tlast_cyc) <= 103), 1);
        sts_never = 0;

        // Run 6: reset while write beat 2 is on the bus, with a start alongside.
        stop_wr = 2;
        start_run(32'h0002_0000, 64'h200, 4'd6);
        serve();
        chk("run6_mid_beat_vld", up0_wr_tvalid, 1);
        drive_idle();
        rst_n = 0;
        piStart = 1;
        @(negedge clk);
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1; piStart = 0;
        stop_wr = -1;

        // Run 7: normal run after reset restarts the tag at 1.
        start_run(32'h0000_3000, 64'h77, 4'd1);
        chk("run7_cmd_hand", up0_wr_cmd_tdata, 72'h1_0000_3000_4080_0100);
        serve();
        chk_result("run7", 1, 16'd0, 0, 4, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/role_mem_tester.md
# role_mem_tester

ROLE-side traffic engine that drives the SHELL memory user port Up0 (DataMover-style command/status/data AXI streams). On a start pulse it writes one burst of a seeded pattern to DDR, reads it back, and compares every beat. It reports pass/fail, a saturating error count and a timeout flag. It replaces the tie-off logic on Up0 and is the first real consumer of the SHELL memory channel.

## Interface
- `BEATS`, 64: 512-bit beats per burst, legal range 1..4096; BTT = BEATS*64 bytes.
- `TIMEOUT`, 65535: cycles allowed in any wait state before abort.
- `piSHL_156_25Clk` in 1: sole clock.
- `piTOP_Reset_n` in 1: reset, synchronous, active-low.
- `piStart` in 1: one-cycle start request; ignored while `poBusy`=1.
- `piAddr` in 32: burst byte address, 64-byte aligned.
- `piSeed` in 64: pattern seed.
- `poBusy`, `poDone`, `poPass`, `poTimeout` out 1: status; `poDone`/`poPass`/`poTimeout` hold until the next accepted start.
- `poErrCnt` out 16: mismatching read beats, saturating at 0xFFFF.
- Up0 RdCmd `tdata[71:0]`/`tvalid` out, `tready` in. RdSts `tdata[7:0]`/`tvalid` in, `tready` out.
- Up0 Read `tdata[511:0]`/`tkeep[63:0]`/`tlast`/`tvalid` in, `tready` out.
- Up0 WrCmd `tdata[71:0]`/`tvalid` out, `tready` in. WrSts `tdata[7:0]`/`tvalid` in, `tready` out.
- Up0 Write `tdata[511:0]`/`tkeep[63:0]`/`tlast`/`tvalid` out, `tready` in.

## Operation
- Command word:
  - [22:0] BTT
  - [23] type = 1 (INCR)
  - [29:24] DSA = 0
  - [30] EOF = 1
  - [31] DRR = 0
  - [63:32] `piAddr` latched
  - [67:64] tag
  - [71:68] 0
- Tag: 4-bit counter, increments on each accepted start and wraps 15→0. Write and read of one run use the same tag.
- Pattern: beat i = 8 × 64-bit word `(seed + i) mod 2^64`. Write tkeep is all ones.
- Status is OK when: [7]=1, [6:4]=0, and [3:0]=tag. Anything else sets the status-error flag.
- FSM sequence: IDLE → WR_CMD → WR_DATA → WR_STS → RD_CMD → RD_DATA → RD_STS → DONE → IDLE.
  - IDLE: on `piStart`, latch addr/seed, clear errors and flags, bump tag → WR_CMD.
  - WR_CMD: WrCmd tvalid held until tready.
  - WR_DATA: BEATS beats; tlast on beat BEATS-1.
  - WR_STS: WrSts tready=1; wait for tvalid.
  - RD_CMD: RdCmd tvalid held until tready.
  - RD_DATA: Read tready=1 and RdSts tready=1. Compare each beat against the expected pattern, with tkeep≠all-ones or tlast≠(i==BEATS-1) also counted as a mismatch. Leave after beat BEATS-1; if a status is accepted early it is recorded.
  - RD_STS: wait for the status unless already recorded.
  - DONE: one cycle; sets `poDone`; `poPass` = errcnt==0 and no status error and no timeout.
- Timeout: a cycle counter resets on every state change and on every handshake. Reaching TIMEOUT in any non-IDLE state → set `poTimeout`, go to DONE, drop all tvalids.
- Read tready and status treadys are 0 in all other states.

## Timing
- Reset (`piTOP_Reset_n`=0 at an edge): all outputs 0 next cycle (tvalids, treadys, flags, count, commands); state IDLE; tag 0.
- Reset mid-burst aborts immediately. This is not AXIS-compliant by design; the SHELL resets concurrently.
- `piStart` at edge n → `poBusy`=1 and WrCmd tvalid=1 at n+1.
- Data beats are registered. Write tdata/tlast stay stable while tvalid=1 and tready=0. Zero-bubble: one beat per cycle when tready is held high.
- Compare result is registered; the error count updates 1 cycle after the beat; DONE waits for the final update.
- `poBusy` falls in the same cycle `poDone` rises.
- `piStart` while busy: no effect.
- Simultaneous `piStart` and reset: reset wins.

## Structure
- Package `role_mem_tester_pkg`:
  - state enum
  - command field offsets, status bit positions
  - `mk_dm_cmd(addr, btt, tag)` function
  - status-OK function
- Sub-module `mem_pattern_gen`: beat counter plus seed adder, with `load`/`advance` inputs. It is instantiated twice, as the write generator and the read checker.

## Test plan
- BEATS=4, seed 0x10, addr 0x1000, always-ready memory model → WrCmd tdata[63:32]=0x1000, BTT=256, tag=1; 4 write beats; read matches; `poPass`=1, `poErrCnt`=0.
- Model corrupts read beat 2 word 0 → `poErrCnt`=1, `poPass`=0.
- Random tready/tvalid gaps at 50% on all streams → pattern intact, `poPass`=1, no beat duplicated or dropped.
- WrSts returns 0x40|tag (SLVERR) → `poPass`=0, `poErrCnt`=0.
- WrSts never returns, TIMEOUT=100 → `poTimeout`=1 about 100 cycles after write tlast, `poDone`=1.
- Reset asserted during beat 2 of WR_DATA → the next cycle all outputs are 0 and state is IDLE. A new start then runs normally with tag 1.
